// File: rtl/zeroriscy_xbar_rr.sv
// rtl/zeroriscy_xbar_rr.sv - two-master (instruction/data) to NS-slave crossbar with blocking transactions
// Optional feature macro: XBAR_RR_EN (per-slave round-robin on conflicts; undefined = dm always wins)
// Master encoding used internally: 0 = data master (dm), 1 = instruction master (im).

module zeroriscy_xbar_rr #(
  parameter int NS = 3,
  parameter logic [NS*32-1:0] S_BASE = {32'h9000_0000, 32'h8010_0000, 32'h8000_0000},
  parameter logic [NS*32-1:0] S_MASK = {3{32'hFFF0_0000}}
) (
  input  logic             clk,
  input  logic             resetn,
  // instruction master
  input  logic             im_req,
  input  logic [31:0]      im_addr,
  output logic             im_gnt,
  output logic             im_rvalid,
  output logic [31:0]      im_rdata,
  output logic             im_err,
  // data master
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [3:0]       dm_be,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [31:0]      dm_rdata,
  output logic             dm_err,
  // slaves
  output logic [NS-1:0]    s_req,
  output logic [NS-1:0]    s_we,
  output logic [4*NS-1:0]  s_be,
  output logic [32*NS-1:0] s_addr,
  output logic [32*NS-1:0] s_wdata,
  input  logic [NS-1:0]    s_gnt,
  input  logic [NS-1:0]    s_rvalid,
  input  logic [NS-1:0]    s_err,
  input  logic [32*NS-1:0] s_rdata
);

  // per-master state: bit 0 = dm, bit 1 = im
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    derr_q, derr_d;
  // per-slave state: owner bit is 1 when im owns the outstanding transaction
  logic [NS-1:0] busy_q, busy_d;
  logic [NS-1:0] owner_q, owner_d;
`ifdef XBAR_RR_EN
  // prio bit is 1 when im is favoured on the next conflict for that slave
  logic [NS-1:0] prio_q, prio_d;
`endif

  logic [NS-1:0] dm_tgt, im_tgt;
  logic          dm_hit, im_hit;
  logic          dm_rv, im_rv, dm_er, im_er;
  logic [31:0]   dm_rd, im_rd;
  logic          dm_elig, im_elig;
  logic          dm_gnt_c, im_gnt_c;
  logic          avail, c_dm, c_im, win_im;

  // address decode: one-hot target per master, lowest matching slave wins
  always_comb begin
    dm_tgt = '0;
    im_tgt = '0;
    dm_hit = 1'b0;
    im_hit = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (!dm_hit && ((dm_addr & S_MASK[32*s +: 32]) == S_BASE[32*s +: 32])) begin
        dm_tgt[s] = 1'b1;
        dm_hit    = 1'b1;
      end
      if (!im_hit && ((im_addr & S_MASK[32*s +: 32]) == S_BASE[32*s +: 32])) begin
        im_tgt[s] = 1'b1;
        im_hit    = 1'b1;
      end
    end
  end

  // response routing: busy slaves answer their owner, decode errors answer one cycle after grant
  always_comb begin
    dm_rv = derr_q[0];
    dm_er = derr_q[0];
    dm_rd = 32'h0;
    im_rv = derr_q[1];
    im_er = derr_q[1];
    im_rd = 32'h0;
    for (int s = 0; s < NS; s++) begin
      if (busy_q[s] && s_rvalid[s]) begin
        if (owner_q[s]) begin
          im_rv = 1'b1;
          im_er = s_err[s];
          im_rd = s_rdata[32*s +: 32];
        end else begin
          dm_rv = 1'b1;
          dm_er = s_err[s];
          dm_rd = s_rdata[32*s +: 32];
        end
      end
    end
  end

  // eligibility, per-slave arbitration, forwarding, grants and next-state
  always_comb begin
    s_req    = '0;
    s_we     = '0;
    s_be     = '0;
    s_addr   = '0;
    s_wdata  = '0;
    dm_gnt_c = 1'b0;
    im_gnt_c = 1'b0;
    busy_d   = busy_q;
    owner_d  = owner_q;
    derr_d   = 2'b00;
    avail    = 1'b0;
    c_dm     = 1'b0;
    c_im     = 1'b0;
    win_im   = 1'b0;
`ifdef XBAR_RR_EN
    prio_d   = prio_q;
`endif
    // a pending master becomes eligible again in the cycle its response arrives
    dm_elig = dm_req & (~pend_q[0] | dm_rv);
    im_elig = im_req & (~pend_q[1] | im_rv);

    for (int s = 0; s < NS; s++) begin
      avail = ~busy_q[s] | s_rvalid[s];
      c_dm  = dm_elig & dm_tgt[s] & avail;
      c_im  = im_elig & im_tgt[s] & avail;
`ifdef XBAR_RR_EN
      win_im = c_im & (~c_dm | prio_q[s]);
`else
      win_im = c_im & ~c_dm;
`endif
      if (c_dm | c_im) begin
        s_req[s] = 1'b1;
        if (win_im) begin
          s_we[s]             = 1'b0;
          s_be[4*s +: 4]      = 4'hF;
          s_addr[32*s +: 32]  = im_addr;
          s_wdata[32*s +: 32] = 32'h0;
        end else begin
          s_we[s]             = dm_we;
          s_be[4*s +: 4]      = dm_be;
          s_addr[32*s +: 32]  = dm_addr;
          s_wdata[32*s +: 32] = dm_wdata;
        end
      end
      if (s_rvalid[s]) begin
        busy_d[s] = 1'b0;
      end
      if ((c_dm | c_im) & s_gnt[s]) begin
        busy_d[s]  = 1'b1;
        owner_d[s] = win_im;
        if (win_im) begin
          im_gnt_c = 1'b1;
        end else begin
          dm_gnt_c = 1'b1;
        end
`ifdef XBAR_RR_EN
        if (c_dm & c_im) begin
          prio_d[s] = ~win_im;
        end
`endif
      end
    end

    // unmapped address: accept immediately, answer with an error next cycle
    if (dm_elig && !dm_hit) begin
      dm_gnt_c  = 1'b1;
      derr_d[0] = 1'b1;
    end
    if (im_elig && !im_hit) begin
      im_gnt_c  = 1'b1;
      derr_d[1] = 1'b1;
    end

    // a new grant keeps the master pending even if its old response arrives now
    pend_d[0] = dm_gnt_c | (pend_q[0] & ~dm_rv);
    pend_d[1] = im_gnt_c | (pend_q[1] & ~im_rv);

    if (!resetn) begin
      s_req   = '0;
      s_we    = '0;
      s_be    = '0;
      s_addr  = '0;
      s_wdata = '0;
    end
  end

  // master-side outputs are forced quiet while reset is held
  assign dm_gnt    = resetn & dm_gnt_c;
  assign im_gnt    = resetn & im_gnt_c;
  assign dm_rvalid = resetn & dm_rv;
  assign im_rvalid = resetn & im_rv;
  assign dm_err    = resetn & dm_er;
  assign im_err    = resetn & im_er;
  assign dm_rdata  = resetn ? dm_rd : 32'h0;
  assign im_rdata  = resetn ? im_rd : 32'h0;

  // state registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q  <= 2'b00;
      derr_q  <= 2'b00;
      busy_q  <= '0;
      owner_q <= '0;
`ifdef XBAR_RR_EN
      prio_q  <= '0;
`endif
    end else begin
      pend_q  <= pend_d;
      derr_q  <= derr_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
`ifdef XBAR_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end

endmodule

// File: tb/tb_zeroriscy_xbar_rr.sv
// tb/tb_zeroriscy_xbar_rr.sv - self-checking bench for zeroriscy_xbar_rr

module tb_zeroriscy_xbar_rr;

  logic        clk = 1'b0;
  logic        resetn;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt, im_rvalid, im_err;
  logic [31:0] im_rdata;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_rdata;
  logic [2:0]  s_req, s_we, s_gnt, s_rvalid, s_err;
  logic [11:0] s_be;
  logic [95:0] s_addr, s_wdata, s_rdata;

  localparam logic [95:0] SLV_DATA = {32'h5300_0003, 32'h5200_0002, 32'h5100_0001};

  zeroriscy_xbar_rr dut (
    .clk(clk), .resetn(resetn),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid),
    .im_rdata(im_rdata), .im_err(im_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        im_req;
    logic [31:0] im_addr;
    logic [2:0]  sgnt;
    logic        e_dm_gnt;
    logic        e_im_gnt;
    logic [2:0]  e_sreq;
    logic [31:0] e_dm_data;
    logic        e_dm_err;
    logic [31:0] e_im_data;
    logic        e_im_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  vec_t vecs[10];
  rsp_t dm_q[$];
  rsp_t im_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic to_im, input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    if (to_im) im_q.push_back(r);
    else       dm_q.push_back(r);
  endtask

  // pop an expected response for every master that reports rvalid now
  task automatic sample_rsp();
    rsp_t r;
    if (dm_rvalid === 1'b1) begin
      if (dm_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dm_spurious_rvalid actual=1 expected=0");
      end else begin
        r = dm_q.pop_front();
        chk("dm_rdata", dm_rdata, r.data);
        chk("dm_err", {31'h0, dm_err}, {31'h0, r.err});
      end
    end
    if (im_rvalid === 1'b1) begin
      if (im_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL im_spurious_rvalid actual=1 expected=0");
      end else begin
        r = im_q.pop_front();
        chk("im_rdata", im_rdata, r.data);
        chk("im_err", {31'h0, im_err}, {31'h0, r.err});
      end
    end
  endtask

  task automatic drained();
    chk("dm_missing_rsp", dm_q.size(), 0);
    chk("im_missing_rsp", im_q.size(), 0);
    dm_q.delete();
    im_q.delete();
  endtask

  task automatic idle_inputs();
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    im_req = 1'b0; im_addr = 32'h0;
    s_gnt = 3'b000; s_rvalid = 3'b000;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    dm_req = v.dm_req; dm_addr = v.dm_addr; dm_we = 1'b0; dm_be = 4'hF;
    im_req = v.im_req; im_addr = v.im_addr;
    s_gnt = v.sgnt; s_rvalid = 3'b000;
    #1;
    chk($sformatf("v%0d_dm_gnt", i), {31'h0, dm_gnt}, {31'h0, v.e_dm_gnt});
    chk($sformatf("v%0d_im_gnt", i), {31'h0, im_gnt}, {31'h0, v.e_im_gnt});
    chk($sformatf("v%0d_s_req", i), {29'h0, s_req}, {29'h0, v.e_sreq});
    if (v.e_dm_gnt) push(1'b0, v.e_dm_data, v.e_dm_err);
    if (v.e_im_gnt) push(1'b1, v.e_im_data, v.e_im_err);
    @(negedge clk);
    dm_req = 1'b0; im_req = 1'b0; s_gnt = 3'b000;
    s_rvalid = v.e_sreq & v.sgnt;
    #1;
    sample_rsp();
    @(negedge clk);
    s_rvalid = 3'b000;
    drained();
  endtask

  logic exp_im;

  initial begin
    //          dm_req dm_addr        im_req im_addr        sgnt    dmg  img  sreq    dm_data        dm_err im_data       im_err
    vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0,         3'b111, 1'b1, 1'b0, 3'b001, 32'h5100_0001, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h8000_0010, 3'b111, 1'b0, 1'b1, 3'b001, 32'h0,         1'b0, 32'h5100_0001, 1'b0};
    vecs[2] = '{1'b1, 32'hA000_0000, 1'b0, 32'h0,         3'b111, 1'b1, 1'b0, 3'b000, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[3] = '{1'b1, 32'h8010_0000, 1'b1, 32'h9000_0004, 3'b111, 1'b1, 1'b1, 3'b110, 32'h5200_0002, 1'b0, 32'h5300_0003, 1'b1};
    vecs[4] = '{1'b1, 32'h9000_0000, 1'b1, 32'h8000_0010, 3'b111, 1'b1, 1'b1, 3'b101, 32'h5300_0003, 1'b1, 32'h5100_0001, 1'b0};
    vecs[5] = '{1'b1, 32'h8010_0000, 1'b1, 32'h8010_0000, 3'b111, 1'b1, 1'b0, 3'b010, 32'h5200_0002, 1'b0, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0,         3'b000, 1'b0, 1'b0, 3'b001, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 32'h0,         1'b1, 32'h9010_0000, 3'b111, 1'b0, 1'b1, 3'b000, 32'h0,         1'b0, 32'h0,         1'b1};
    vecs[8] = '{1'b1, 32'h800F_FFFC, 1'b1, 32'h8010_0000, 3'b011, 1'b1, 1'b1, 3'b011, 32'h5100_0001, 1'b0, 32'h5200_0002, 1'b0};
    vecs[9] = '{1'b0, 32'h0,         1'b0, 32'h0,         3'b111, 1'b0, 1'b0, 3'b000, 32'h0,         1'b0, 32'h0,         1'b0};

    s_rdata = SLV_DATA;
    s_err   = 3'b100;
    idle_inputs();

    // reset held with live requests: everything stays quiet
    resetn = 1'b0;
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'hA000_0000;
    im_req = 1'b1; im_addr = 32'h8000_0010;
    s_gnt = 3'b111; s_rvalid = 3'b111;
    #1;
    chk("rst_dm_gnt", {31'h0, dm_gnt}, 32'h0);
    chk("rst_im_gnt", {31'h0, im_gnt}, 32'h0);
    chk("rst_s_req", {29'h0, s_req}, 32'h0);
    chk("rst_rvalid", {30'h0, dm_rvalid, im_rvalid}, 32'h0);
    chk("rst_err", {30'h0, dm_err, im_err}, 32'h0);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // im read from slave 0 answered two cycles after the grant
    @(negedge clk);
    im_req = 1'b1; im_addr = 32'h8000_0010; s_gnt = 3'b001;
    s_rdata[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("a_im_gnt", {31'h0, im_gnt}, 32'h1);
    chk("a_s_req", {29'h0, s_req}, 32'h1);
    chk("a_s_addr0", s_addr[31:0], 32'h8000_0010);
    chk("a_s_be0", {28'h0, s_be[3:0]}, 32'hF);
    chk("a_s_we0", {31'h0, s_we[0]}, 32'h0);
    push(1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    im_req = 1'b0; s_gnt = 3'b000;
    #1;
    chk("a_im_rvalid_c1", {31'h0, im_rvalid}, 32'h0);
    @(negedge clk);
    s_rvalid = 3'b001;
    #1;
    sample_rsp();
    @(negedge clk);
    s_rvalid = 3'b000;
    s_rdata = SLV_DATA;
    drained();

    // conflict sequence on slave 1 starting from reset
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dm_req = 1'b1; dm_addr = 32'h8010_0000;
      im_req = 1'b1; im_addr = 32'h8010_0008;
      s_gnt = 3'b010;
      s_rvalid = (i > 0) ? 3'b010 : 3'b000;
      #1;
      sample_rsp();
`ifdef XBAR_RR_EN
      exp_im = (i % 2) == 1;
`else
      exp_im = 1'b0;
`endif
      chk($sformatf("rr%0d_dm_gnt", i), {31'h0, dm_gnt}, {31'h0, ~exp_im});
      chk($sformatf("rr%0d_im_gnt", i), {31'h0, im_gnt}, {31'h0, exp_im});
      push(exp_im, 32'h5200_0002, 1'b0);
    end
    @(negedge clk);
    idle_inputs();
    s_rvalid = 3'b010;
    #1;
    sample_rsp();
    @(negedge clk);
    s_rvalid = 3'b000;
    drained();

    // dm holds slave 1 while im waits behind it
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; dm_addr = 32'h8010_0000; dm_wdata = 32'hCAFE_0001;
    s_gnt = 3'b010;
    #1;
    chk("c_dm_gnt", {31'h0, dm_gnt}, 32'h1);
    chk("c_s_req", {29'h0, s_req}, 32'h2);
    chk("c_s_addr1", s_addr[63:32], 32'h8010_0000);
    chk("c_s_we1", {31'h0, s_we[1]}, 32'h1);
    chk("c_s_be1", {28'h0, s_be[7:4]}, 32'h3);
    chk("c_s_wdata1", s_wdata[63:32], 32'hCAFE_0001);
    chk("c_s_addr0_idle", s_addr[31:0], 32'h0);
    push(1'b0, 32'h5200_0002, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dm_req = 1'b0; dm_we = 1'b0;
      im_req = 1'b1; im_addr = 32'h8010_0004; s_gnt = 3'b010; s_rvalid = 3'b000;
      #1;
      sample_rsp();
      chk($sformatf("c_wait%0d_im_gnt", k), {31'h0, im_gnt}, 32'h0);
      chk($sformatf("c_wait%0d_s_req", k), {29'h0, s_req}, 32'h0);
    end
    @(negedge clk);
    s_rvalid = 3'b010;
    #1;
    sample_rsp();
    chk("c_im_gnt_on_rvalid", {31'h0, im_gnt}, 32'h1);
    push(1'b1, 32'h5200_0002, 1'b0);
    @(negedge clk);
    im_req = 1'b0; s_gnt = 3'b000; s_rvalid = 3'b010;
    #1;
    sample_rsp();
    @(negedge clk);
    s_rvalid = 3'b000;
    drained();

    // reset mid-transaction discards it and frees the slave
    @(negedge clk);
    dm_req = 1'b1; dm_addr = 32'h8010_0000; s_gnt = 3'b010;
    #1;
    chk("r_dm_gnt", {31'h0, dm_gnt}, 32'h1);
    @(negedge clk);
    dm_req = 1'b0; s_gnt = 3'b000;
    @(negedge clk);
    resetn = 1'b0;
    im_req = 1'b1; im_addr = 32'h8010_0004; s_gnt = 3'b010; s_rvalid = 3'b010;
    #1;
    chk("r_gnt", {30'h0, dm_gnt, im_gnt}, 32'h0);
    chk("r_rvalid", {30'h0, dm_rvalid, im_rvalid}, 32'h0);
    chk("r_err", {30'h0, dm_err, im_err}, 32'h0);
    chk("r_s_req", {29'h0, s_req}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    im_req = 1'b0; s_gnt = 3'b000; s_rvalid = 3'b010;
    #1;
    chk("r_stray_rvalid", {30'h0, dm_rvalid, im_rvalid}, 32'h0);
    @(negedge clk);
    s_rvalid = 3'b000; im_req = 1'b1; s_gnt = 3'b010;
    #1;
    chk("r_im_gnt_free", {31'h0, im_gnt}, 32'h1);
    push(1'b1, 32'h5200_0002, 1'b0);
    @(negedge clk);
    im_req = 1'b0; s_gnt = 3'b000; s_rvalid = 3'b010;
    #1;
    sample_rsp();
    @(negedge clk);
    s_rvalid = 3'b000;
    drained();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
